// File: rtl/song_player.sv
// Autoplay sequencer: walks a synchronous song ROM, holds each note for its
// encoded duration with a trailing silence, and handles next/previous song selection.
module song_player #(
    parameter int NUM_SONGS  = 4,
    parameter int SONG_W     = 2,
    parameter int POS_W      = 5,
    parameter int TICK_DIV   = 25_000_000,
    parameter int GAP_CYCLES = 2_500_000,
    parameter int LOOP       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [1:0]              song_select,
    output logic [SONG_W+POS_W-1:0] rom_addr,
    input  logic [7:0]              rom_data,
    output logic [3:0]              note_out,
    output logic [6:0]              led_out,
    output logic [SONG_W-1:0]       song_idx,
    output logic                    playing,
    output logic                    song_done
);

    localparam int CYC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TICK_DIV - 1);
    localparam logic [CYC_W-1:0]  GAP_START = CYC_W'(TICK_DIV - GAP_CYCLES);
    localparam logic [POS_W-1:0]  POS_LAST  = '1;
    localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(NUM_SONGS - 1);

    logic [2:0]        state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [1:0]        sel_q;
    logic [3:0]        note_q, note_d;
    logic [3:0]        dur_q, dur_d;
    logic [3:0]        tick_q, tick_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              done_q, done_d;

    logic nxt_edge, prv_edge, chg;
    logic last_tick, in_gap;

    assign nxt_edge  = song_select[0] & ~sel_q[0];
    assign prv_edge  = song_select[1] & ~sel_q[1];
    // Simultaneous next and previous cancel out.
    assign chg       = nxt_edge ^ prv_edge;

    assign last_tick = (tick_q == dur_q - 4'd1);
    assign in_gap    = (GAP_CYCLES > 0) && last_tick && (cyc_q >= GAP_START);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        song_d  = song_q;
        note_d  = note_q;
        dur_d   = dur_q;
        tick_d  = tick_q;
        cyc_d   = cyc_q;
        done_d  = 1'b0;

        if (chg) begin
            if (nxt_edge) song_d = (song_q == SONG_LAST) ? '0 : song_q + SONG_W'(1);
            else          song_d = (song_q == '0) ? SONG_LAST : song_q - SONG_W'(1);
            pos_d   = '0;
            state_d = enable ? S_FETCH : S_IDLE;
        end else if (!enable) begin
            pos_d   = '0;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    if (rom_data[3:0] == 4'd0) begin
                        pos_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        note_d  = rom_data[7:4];
                        dur_d   = rom_data[3:0];
                        tick_d  = 4'd0;
                        cyc_d   = '0;
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_d  = '0;
                        tick_d = tick_q + 4'd1;
                        if (last_tick) begin
                            if (pos_q == POS_LAST) begin
                                pos_d   = '0;
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                pos_d   = pos_q + POS_W'(1);
                                state_d = S_FETCH;
                            end
                        end
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end
                S_DONE: begin
                    if (LOOP != 0) state_d = S_FETCH;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            song_q  <= '0;
            sel_q   <= song_select;
            note_q  <= 4'd0;
            dur_q   <= 4'd0;
            tick_q  <= 4'd0;
            cyc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            song_q  <= song_d;
            sel_q   <= song_select;
            note_q  <= note_d;
            dur_q   <= dur_d;
            tick_q  <= tick_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
        end
    end

    assign rom_addr  = {song_q, pos_q};
    assign song_idx  = song_q;
    assign song_done = done_q;
    assign playing   = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_PLAY);
    assign note_out  = ((state_q == S_PLAY) && !in_gap) ? note_q : 4'd0;

    always_comb begin
        led_out = 7'd0;
        if (note_out >= 4'd1 && note_out <= 4'd7)
            led_out[note_out - 4'd1] = 1'b1;
        else if (note_out >= 4'd8 && note_out <= 4'd14)
            led_out[note_out - 4'd8] = 1'b1;
    end

endmodule

// File: tb/tb_song_player.sv
// Bench for song_player: a non-looping and a looping instance share stimulus;
// expected output traces are built from the note/duration rules of the ROM contents.
module tb_song_player;

    localparam int TD  = 4;
    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst, enable;
    logic [1:0] sel;
    logic [4:0] addr0, addr1;
    logic [7:0] rd0, rd1;
    logic [3:0] note0, note1;
    logic [6:0] led0, led1;
    logic [1:0] idx0, idx1;
    logic       play0, play1, done0, done1;

    logic [7:0]  rom [0:31];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] sel;
        logic [1:0] idx;
    } sel_vec_t;
    sel_vec_t sel_tab[8];

    always #5 clk = ~clk;

    song_player #(.NUM_SONGS(4), .SONG_W(2), .POS_W(3), .TICK_DIV(TD),
                  .GAP_CYCLES(GAP), .LOOP(0)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .song_select(sel),
        .rom_addr(addr0), .rom_data(rd0), .note_out(note0), .led_out(led0),
        .song_idx(idx0), .playing(play0), .song_done(done0));

    song_player #(.NUM_SONGS(4), .SONG_W(2), .POS_W(3), .TICK_DIV(TD),
                  .GAP_CYCLES(GAP), .LOOP(1)) u_loop (
        .clk(clk), .rst(rst), .enable(enable), .song_select(sel),
        .rom_addr(addr1), .rom_data(rd1), .note_out(note1), .led_out(led1),
        .song_idx(idx1), .playing(play1), .song_done(done1));

    always @(posedge clk) begin
        rd0 <= rom[addr0];
        rd1 <= rom[addr1];
    end

    function automatic logic [6:0] led_of(input logic [3:0] n);
        if (n >= 1 && n <= 7)  return 7'(1 << (n - 1));
        if (n >= 8 && n <= 14) return 7'(1 << (n - 8));
        return 7'd0;
    endfunction

    function automatic logic [31:0] pk(input logic [3:0] n, input logic [6:0] l,
                                       input logic d, input logic p, input logic [4:0] a);
        return {14'd0, n, l, d, p, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit lp, input logic [3:0] n, input bit d, input bit p,
                        input int song, input int pos);
        logic [31:0] v;
        v = pk(n, led_of(n), d, p, 5'(song * 8 + pos));
        if (lp) q1.push_back(v);
        else    q0.push_back(v);
    endtask

    function automatic int qsz(input bit lp);
        return lp ? q1.size() : q0.size();
    endfunction

    // Expected per-cycle trace from the cycle after enable rises.
    task automatic build(input int song, input bit lp, input int n);
        int pos;
        int dur;
        logic [3:0] nt;
        bit stop;
        pos  = 0;
        stop = 1'b0;
        if (lp) q1.delete();
        else    q0.delete();
        while (qsz(lp) < n) begin
            if (stop) push(lp, 4'd0, 0, 0, song, 0);
            else begin
                push(lp, 4'd0, 0, 1, song, pos);
                push(lp, 4'd0, 0, 1, song, pos);
                dur = int'(rom[song * 8 + pos][3:0]);
                nt  = rom[song * 8 + pos][7:4];
                if (dur == 0) begin
                    push(lp, 4'd0, 1, 0, song, 0);
                    pos  = 0;
                    stop = !lp;
                end else begin
                    for (int c = 0; c < dur * TD; c++)
                        push(lp, (c >= dur * TD - GAP) ? 4'd0 : nt, 0, 1, song, pos);
                    if (pos == 7) begin
                        push(lp, 4'd0, 1, 0, song, 0);
                        pos  = 0;
                        stop = !lp;
                    end else pos++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; sel = 2'b00;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [1:0] p);
        sel = p; step();
        sel = 2'b00; step();
    endtask

    task automatic setup(input int song);
        do_reset();
        for (int i = 0; i < song; i++) pulse(2'b01);
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    endtask

    task automatic run(input string tag, input int song, input int n);
        build(song, 1'b0, n);
        build(song, 1'b1, n);
        enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("%s nl cyc%0d", tag, i), pk(note0, led0, done0, play0, addr0), q0[i]);
            check($sformatf("%s lp cyc%0d", tag, i), pk(note1, led1, done1, play1, addr1), q1[i]);
        end
        enable = 1'b0;
        step();
    endtask

    task automatic wait_note(input string tag, input logic [4:0] a, input logic [3:0] n);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step();
            if (addr0 == a && note0 == n) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s wait: addr/note %0h/%0h never seen", tag, a, n);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; sel = 2'b00;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;

        do_reset();
        check("reset outputs", pk(note0, led0, done0, play0, addr0), 32'd0);
        check("reset song_idx", {30'd0, idx0}, 32'd0);

        // Song selection table, player idle.
        sel_tab[0] = '{2'b01, 2'd1};
        sel_tab[1] = '{2'b01, 2'd2};
        sel_tab[2] = '{2'b01, 2'd3};
        sel_tab[3] = '{2'b01, 2'd0};
        sel_tab[4] = '{2'b10, 2'd3};
        sel_tab[5] = '{2'b11, 2'd3};
        sel_tab[6] = '{2'b10, 2'd2};
        sel_tab[7] = '{2'b11, 2'd2};
        for (int i = 0; i < 8; i++) begin
            sel = sel_tab[i].sel;
            step();
            check($sformatf("select vec%0d", i), {29'd0, play0, idx0}, {29'd0, 1'b0, sel_tab[i].idx});
            sel = 2'b00;
            step();
        end

        // Basic timing.
        setup(0);
        rom[0] = 8'h12; rom[1] = 8'h31; rom[2] = 8'h00;
        run("basic", 0, 40);

        // Loop and wrap: eight entries, no end marker.
        setup(1);
        for (int i = 0; i < 8; i++) rom[8 + i] = {4'(i + 1), 4'd1};
        run("wrap", 1, 110);

        // Randomized songs.
        for (int it = 0; it < 5; it++) begin
            int song;
            int mark;
            song = $urandom_range(0, 3);
            setup(song);
            mark = $urandom_range(0, 15);
            for (int i = 0; i < 8; i++)
                rom[song * 8 + i] = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 3))};
            if (mark < 8) rom[song * 8 + mark] = {4'($urandom_range(0, 15)), 4'd0};
            run($sformatf("rand%0d", it), song, 160);
        end

        // Mid-note abort into song 1.
        setup(0);
        rom[0] = 8'h12; rom[1] = 8'h31; rom[2] = 8'h00;
        rom[8] = 8'h53; rom[9] = 8'h00;
        enable = 1'b1;
        wait_note("abort", 5'd1, 4'd3);
        sel = 2'b01;
        step();
        check("abort fetch", pk(note0, led0, done0, play0, addr0), pk(4'd0, 7'd0, 0, 1, 5'd8));
        sel = 2'b00;
        step();
        check("abort load note", {28'd0, note0}, 32'd0);
        step();
        check("abort new note", pk(note0, led0, done0, play0, addr0), pk(4'd5, 7'b0010000, 0, 1, 5'd8));
        check("abort song_idx", {30'd0, idx0}, 32'd1);

        // Reset mid-note.
        step();
        rst = 1'b1;
        step();
        check("midnote reset", pk(note0, led0, done0, play0, addr0), 32'd0);
        check("midnote reset idx", {30'd0, idx0}, 32'd0);
        rst = 1'b0;
        enable = 1'b0;
        step();

        // Enable drop mid-note, then restart from entry 0.
        enable = 1'b1;
        wait_note("drop", 5'd1, 4'd3);
        enable = 1'b0;
        step();
        check("drop idle", pk(note0, led0, done0, play0, addr0), 32'd0);
        enable = 1'b1;
        step();
        check("reenable fetch", pk(note0, led0, done0, play0, addr0), pk(4'd0, 7'd0, 0, 1, 5'd0));
        step();
        step();
        check("reenable note", pk(note0, led0, done0, play0, addr0), pk(4'd1, 7'b0000001, 0, 1, 5'd0));
        enable = 1'b0;
        step();

        // Select held high through reset release gives no edge.
        rst = 1'b1; sel = 2'b01;
        step(); step();
        rst = 1'b0;
        step(); step();
        check("held select idx", {30'd0, idx0}, 32'd0);
        sel = 2'b00;
        step();
        check("held select release idx", {30'd0, idx0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/song_player.md
Name: song_player

Overview:
- Autoplay sequencer for the piano's "play song" mode. It sits directly upstream of the Buzzer and drives the same 4-bit note code and 7-bit LED bus that the Controller drives in free-play mode.
- It walks a synchronous song ROM, holds each note for its encoded duration, and inserts a short silence between notes.
- It handles next/previous song selection.
- Top-level muxing between Controller and song_player outputs is done by mode.

Parameters:
- NUM_SONGS, 4, number of songs in ROM; power of two, 2..16.
- SONG_W, 2, log2(NUM_SONGS).
- POS_W, 5, entry index width; 2**POS_W entries per song.
- TICK_DIV, 25_000_000, clk cycles per duration tick (0.25 s at 100 MHz).
- GAP_CYCLES, 2_500_000, silent cycles at the end of each note; must be < TICK_DIV.
- LOOP, 0, 1 = restart the song after its end marker; 0 = stop.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  autoplay active (mode decode from top)
- song_select  in  2  bit0 = next, bit1 = previous; debounced upstream, acted on at rising edge
- rom_addr  out  SONG_W+POS_W  {song_idx, pos}, combinational from registers
- rom_data  in  8  {note[7:4], dur[3:0]}; valid one cycle after rom_addr is presented
- note_out  out  4  0 = rest, 1..7 = do..ti, 8..14 = upper octave, 15 = treated as rest
- led_out  out  7  one-hot scale degree of note_out
- song_idx  out  SONG_W  current song
- playing  out  1  high in FETCH/LOAD/PLAY
- song_done  out  1  one-cycle pulse when a song ends

Behaviour:
- Reset values: note_out=0, led_out=0, song_idx=0, playing=0, song_done=0, pos=0, tick/cycle counters=0, state=IDLE.
- Reset loads the song_select edge registers with the current input, so a held input gives no spurious edge.
- FSM states: IDLE, FETCH, LOAD, PLAY, DONE.
- IDLE:
  - silent, pos=0.
  - enable=1 -> FETCH.
- FETCH (1 cycle):
  - rom_addr={song_idx,pos}; note_out=0.
  - Always -> LOAD.
- LOAD (1 cycle):
  - Capture rom_data.
  - If dur==0 (end marker) -> DONE.
  - Otherwise latch note and dur, clear counters, -> PLAY.
- PLAY:
  - Lasts exactly dur*TICK_DIV cycles.
  - note_out = latched note, except 0 during the final GAP_CYCLES cycles.
  - On the last cycle: if pos == 2**POS_W-1 -> DONE (implicit end); else pos+1 -> FETCH.
  - Note-to-note period is dur*TICK_DIV + 2 cycles.
- DONE:
  - song_done=1 for the entry cycle only; note_out=0; pos=0.
  - If LOOP=1 -> FETCH on the next cycle.
  - If LOOP=0, hold until enable falls (-> IDLE) or a song change occurs.
- enable falling in any state -> IDLE next cycle; note_out=0 and pos=0 from that cycle.
- Song change:
  - Next edge: song_idx = song_idx+1 mod NUM_SONGS. Previous edge: song_idx = song_idx-1 mod NUM_SONGS.
  - Both edges in the same cycle: ignored.
  - A change aborts the current note, sets pos=0, and goes to FETCH if enable=1, else stays IDLE.
  - Edges take effect the cycle after detection; they are accepted in every state.
- led_out:
  - note 1..7 -> led_out[note-1].
  - note 8..14 -> led_out[note-8].
  - Otherwise 0.
  - Combinational from note_out, so it is dark during gaps.
- playing = state in {FETCH, LOAD, PLAY}.
- rst asserted mid-note overrides everything and returns all outputs to reset values next cycle.

Test Plan (TICK_DIV=4, GAP_CYCLES=1, POS_W=3 unless noted; ROM model is registered, 1-cycle latency):
- Basic timing: song0 = {0x12, 0x31, 0x00}; raise enable. Required response:
  - note_out=1 for 7 cycles, then 0 for 1 cycle.
  - 2 cycles of 0 (FETCH/LOAD).
  - note_out=3 for 3 cycles, then 0 for 1 cycle.
  - 2 cycles of 0, then song_done pulses once; playing=0 afterwards.
  - led_out=0000001, then 0000100 while the notes sound.
- Loop and wrap: LOOP=1, song1 has 8 nonzero entries and no end marker. Required: pos wraps 7 -> 0, song_done pulses after entry 7, and rom_addr returns to {1,0}.
- Selection: song_idx=3, pulse next -> song_idx=0. Pulse previous -> song_idx=3. Both bits rise together -> song_idx unchanged.
- Mid-note abort: during PLAY of song0 entry 1, pulse next. Required: within 2 cycles note_out=0 and rom_addr={1,0}, and song1 entry 0 plays.
- Enable drop and reset: drop enable mid-note -> note_out=0 and state IDLE the next cycle; re-enable restarts at pos 0. Assert rst mid-note -> all outputs at reset values.
- Reset with song_select=01 held through release: song_idx stays 0.
